// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SCAN
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic logic [255:0] onehot(input logic [7:0] sel);
    return 256'(1) << sel;
  endfunction

endpackage

// File: rtl/scan_step_counter.sv
// Scan index walker: holds the output index and its dwell countdown,
// and flags the cycle where the index wraps back to zero.
module scan_step_counter #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  logic [SEL_W-1:0]   idx_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               act_q;
  logic               wrap_q;

  // First run cycle loads idx 0 without stepping or flagging a wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || clr || !run) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else if (!act_q) begin
      idx_q  <= '0;
      cnt_q  <= dwell;
      act_q  <= 1'b1;
      wrap_q <= 1'b0;
    end else if (cnt_q == '0) begin
      idx_q  <= idx_q + SEL_W'(1);
      cnt_q  <= dwell;
      wrap_q <= (idx_q == IDX_MAX);
    end else begin
      cnt_q  <= cnt_q - DWELL_W'(1);
      wrap_q <= 1'b0;
    end
  end

  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with handshake input,
// pulse/hold direct mode and an autonomous dwell-timed scan mode.
module decoder_nto2n_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                pulse,
  input  logic                in_valid,
  input  logic [SEL_W-1:0]    in,
  output logic                in_ready,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**SEL_W-1:0] out,
  output logic                out_valid,
  output logic                scan_wrap
);

  localparam int OUT_W = 2**SEL_W;

  dec_state_t       state_q;
  logic [OUT_W-1:0] dir_q;
  logic             mode_q;
  logic             mode_chg;
  logic             xfer;
  logic             clr;
  logic             run;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  assign in_ready = en && (mode == MODE_DIRECT);
  assign xfer     = in_valid && in_ready;
  assign mode_chg = (mode != mode_q);
  assign clr      = !en || mode_chg;
  assign run      = en && (mode == MODE_SCAN) && !mode_chg;

  scan_step_counter #(
    .SEL_W  (SEL_W),
    .DWELL_W(DWELL_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .run  (run),
    .dwell(dwell),
    .idx  (idx),
    .wrap (wrap)
  );

  // mode_q tracks mode even through reset/disable so that only a
  // real change while enabled costs the one-cycle IDLE gap.
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (!rst_n || !en || mode_chg) begin
      state_q <= IDLE;
      dir_q   <= '0;
    end else if (mode == MODE_SCAN) begin
      state_q <= SCAN;
      dir_q   <= '0;
    end else if (xfer) begin
      state_q <= pulse ? IDLE : HOLD;
      dir_q   <= OUT_W'(onehot(8'(in)));
    end else if (state_q != HOLD) begin
      state_q <= IDLE;
      dir_q   <= '0;
    end
  end

  assign out = (state_q == SCAN) ? OUT_W'(onehot(8'(idx))) : dir_q;
  assign out_valid = |out;
  assign scan_wrap = wrap;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Bench for decoder_nto2n_scan: directed vector table, hand-written
// scan sequences and randomized traffic against a behavioural model.
module tb_decoder_nto2n_scan;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, pulse, in_valid;
  logic [2:0] din;
  logic [3:0] dwell;
  logic       in_ready;
  logic [7:0] dout;
  logic       out_valid, scan_wrap;

  int passed = 0;
  int total  = 0;

  // behavioural model state
  int m_out = 0;
  int m_wrap = 0;
  int m_pos = 0;
  int m_left = 0;
  bit m_scanning = 0;
  bit m_held = 0;
  bit m_prev_mode = 0;

  always #5 clk = ~clk;

  decoder_nto2n_scan #(.SEL_W(3), .DWELL_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .pulse    (pulse),
    .in_valid (in_valid),
    .in       (din),
    .in_ready (in_ready),
    .dwell    (dwell),
    .out      (dout),
    .out_valid(out_valid),
    .scan_wrap(scan_wrap)
  );

  typedef struct {
    bit       r, e, m, p, v;
    bit [2:0] i;
    bit [7:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  task automatic model_step();
    if (!rst_n || !en || (mode != m_prev_mode)) begin
      m_out = 0; m_wrap = 0; m_scanning = 0; m_held = 0;
    end else if (mode) begin
      m_held = 0;
      if (!m_scanning) begin
        m_scanning = 1; m_pos = 0; m_left = int'(dwell); m_wrap = 0;
      end else if (m_left == 0) begin
        m_wrap = (m_pos == 7) ? 1 : 0;
        m_pos = (m_pos + 1) % 8;
        m_left = int'(dwell);
      end else begin
        m_left = m_left - 1; m_wrap = 0;
      end
      m_out = 1 << m_pos;
    end else begin
      m_scanning = 0; m_wrap = 0;
      if (in_valid) begin
        m_out = 1 << din;
        m_held = !pulse;
      end else if (!m_held) begin
        m_out = 0;
      end
    end
    m_prev_mode = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    check("in_ready", 32'(in_ready), 32'(en && !mode));
    model_step();
    #1;
    check("model_out", 32'(dout), 32'(m_out));
    check("model_out_valid", 32'(out_valid), 32'(m_out != 0));
    check("model_scan_wrap", 32'(scan_wrap), 32'(m_wrap));
  endtask

  task automatic drive(bit r, bit e, bit m, bit p, bit v, bit [2:0] i);
    rst_n = r; en = e; mode = m; pulse = p; in_valid = v; din = i;
  endtask

  logic [7:0] exp8;

  initial begin
    drive(0, 1, 0, 0, 1, 3'd5);
    dwell = 4'd0;

    // reset, direct hold, direct pulse
    vecs.push_back('{0, 1, 0, 0, 1, 3'd5, 8'h00});
    vecs.push_back('{0, 1, 0, 0, 1, 3'd5, 8'h00});
    vecs.push_back('{1, 1, 0, 0, 0, 3'd0, 8'h00});
    vecs.push_back('{1, 1, 0, 0, 1, 3'd3, 8'h08});
    vecs.push_back('{1, 1, 0, 0, 0, 3'd7, 8'h08});
    vecs.push_back('{1, 1, 0, 0, 1, 3'd6, 8'h40});
    vecs.push_back('{1, 1, 0, 1, 0, 3'd1, 8'h40});
    vecs.push_back('{1, 1, 0, 0, 0, 3'd1, 8'h40});
    vecs.push_back('{1, 0, 0, 0, 0, 3'd1, 8'h00});
    vecs.push_back('{1, 1, 0, 1, 1, 3'd0, 8'h01});
    vecs.push_back('{1, 1, 0, 1, 1, 3'd1, 8'h02});
    vecs.push_back('{1, 1, 0, 1, 1, 3'd2, 8'h04});
    vecs.push_back('{1, 1, 0, 1, 0, 3'd2, 8'h00});
    vecs.push_back('{1, 1, 0, 1, 0, 3'd2, 8'h00});

    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].e, vecs[k].m, vecs[k].p, vecs[k].v, vecs[k].i);
      tick();
      check($sformatf("vec%0d_out", k), 32'(dout), 32'(vecs[k].exp_out));
      check($sformatf("vec%0d_valid", k), 32'(out_valid),
            32'(vecs[k].exp_out != 8'h00));
      check($sformatf("vec%0d_wrap", k), 32'(scan_wrap), 32'(0));
    end

    // scan with dwell=1: gap cycle, then 2 clks per output
    drive(1, 1, 1, 0, 0, 3'd0);
    dwell = 4'd1;
    tick();
    check("scan1_gap", 32'(dout), 32'(0));
    for (int k = 0; k < 34; k++) begin
      tick();
      exp8 = 8'(1) << ((k / 2) % 8);
      check("scan1_out", 32'(dout), 32'(exp8));
      check("scan1_wrap", 32'(scan_wrap), 32'((k > 0) && (k % 16 == 0)));
    end

    // scan dwell=0 changed to 2 at idx 4, then back to direct
    en = 0;
    tick();
    check("scan2_off", 32'(dout), 32'(0));
    en = 1; dwell = 4'd0;
    tick();
    check("scan2_entry", 32'(dout), 32'h01);
    check("scan2_nowrap", 32'(scan_wrap), 32'(0));
    for (int j = 1; j <= 4; j++) begin
      tick();
      exp8 = 8'(1) << j;
      check("scan2_fast", 32'(dout), 32'(exp8));
    end
    dwell = 4'd2;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("scan2_idx5", 32'(dout), 32'h20);
    end
    tick();
    check("scan2_idx6", 32'(dout), 32'h40);
    mode = 0;
    tick();
    check("scan2_exit_gap", 32'(dout), 32'(0));
    check("scan2_ready", 32'(in_ready), 32'(1));
    drive(1, 1, 0, 1, 1, 3'd2);
    tick();
    check("scan2_direct", 32'(dout), 32'h04);
    in_valid = 0;
    tick();
    check("scan2_direct_clr", 32'(dout), 32'(0));

    // reset mid-scan, re-entry, disable with a pending transfer
    drive(1, 1, 1, 0, 0, 3'd0);
    dwell = 4'd0;
    tick();
    check("scan3_gap", 32'(dout), 32'(0));
    for (int j = 0; j <= 5; j++) begin
      tick();
      exp8 = 8'(1) << j;
      check("scan3_walk", 32'(dout), 32'(exp8));
    end
    rst_n = 0;
    tick();
    check("scan3_rst", 32'(dout), 32'(0));
    check("scan3_rst_valid", 32'(out_valid), 32'(0));
    rst_n = 1;
    tick();
    check("scan3_restart", 32'(dout), 32'h01);
    tick();
    check("scan3_step", 32'(dout), 32'h02);
    drive(1, 0, 0, 0, 1, 3'd4);
    tick();
    check("dis_xfer", 32'(dout), 32'(0));
    drive(1, 1, 0, 0, 1, 3'd4);
    tick();
    check("hold_xfer", 32'(dout), 32'h10);
    drive(1, 0, 0, 0, 1, 3'd5);
    tick();
    check("dis_hold", 32'(dout), 32'(0));

    // randomized traffic against the model
    drive(1, 1, 0, 0, 0, 3'd0);
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      en       = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      pulse    = 1'($urandom);
      in_valid = ($urandom_range(0, 2) != 0);
      din      = 3'($urandom);
      if ($urandom_range(0, 7) == 0) dwell = 4'($urandom_range(0, 3));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
